// File: rtl/axis_frame_receiver.sv
// Deserialises a 32-bit AXI-Stream ciphertext frame (key, nonce, counter, payload)
// into one parallel frame with tlast framing checks, resync and statistics.
module axis_frame_receiver #(
    parameter int KEY_WORDS   = 8,
    parameter int NONCE_WORDS = 2,
    parameter int CTR_WORDS   = 2,
    parameter int DATA_WORDS  = 16,
    parameter int CNT_W       = 16
) (
    input  logic                      axis_clk,
    input  logic                      axis_reset_n,
    input  logic                      s_axis_valid,
    input  logic [31:0]               s_axis_data,
    input  logic                      s_axis_last,
    output logic                      s_axis_ready,
    output logic                      frm_valid,
    input  logic                      frm_ready,
    output logic [KEY_WORDS*32-1:0]   frm_key,
    output logic [NONCE_WORDS*32-1:0] frm_nonce,
    output logic [CTR_WORDS*32-1:0]   frm_counter,
    output logic [DATA_WORDS*32-1:0]  frm_data,
    output logic                      frm_err,
    output logic [CNT_W-1:0]          frm_count,
    output logic [CNT_W-1:0]          err_count
);

    localparam int FRAME_WORDS = KEY_WORDS + NONCE_WORDS + CTR_WORDS + DATA_WORDS;
    localparam int IDX_W       = $clog2(FRAME_WORDS);
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(FRAME_WORDS - 1);
    localparam logic [IDX_W-1:0] NONCE_BASE = IDX_W'(KEY_WORDS);
    localparam logic [IDX_W-1:0] CTR_BASE   = IDX_W'(KEY_WORDS + NONCE_WORDS);
    localparam logic [IDX_W-1:0] DATA_BASE  = IDX_W'(KEY_WORDS + NONCE_WORDS + CTR_WORDS);

    typedef enum logic [1:0] {
        ST_COLLECT = 2'd0,
        ST_DRAIN   = 2'd1,
        ST_HOLD    = 2'd2
    } state_t;

    state_t                      state_r;
    state_t                      state_nxt_s;
    logic [IDX_W-1:0]            idx_r;
    logic                        ready_r;
    logic                        valid_r;
    logic                        err_r;
    logic [KEY_WORDS*32-1:0]     key_r;
    logic [NONCE_WORDS*32-1:0]   nonce_r;
    logic [CTR_WORDS*32-1:0]     ctr_r;
    logic [DATA_WORDS*32-1:0]    data_r;
    logic [CNT_W-1:0]            frm_cnt_r;
    logic [CNT_W-1:0]            err_cnt_r;
    logic                        accept_s;
    logic                        store_s;
    logic                        frame_err_s;
    logic                        idx_clr_s;
    logic                        deliver_s;

    assign accept_s     = s_axis_valid && ready_r;
    assign s_axis_ready = ready_r;
    assign frm_valid    = valid_r;
    assign frm_err      = err_r;
    assign frm_key      = key_r;
    assign frm_nonce    = nonce_r;
    assign frm_counter  = ctr_r;
    assign frm_data     = data_r;
    assign frm_count    = frm_cnt_r;
    assign err_count    = err_cnt_r;

    // State register
    always_ff @(posedge axis_clk or negedge axis_reset_n) begin
        if (!axis_reset_n) begin
            state_r <= ST_COLLECT;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode and per-cycle control strobes
    always_comb begin
        state_nxt_s = state_r;
        store_s     = 1'b0;
        frame_err_s = 1'b0;
        idx_clr_s   = 1'b0;
        deliver_s   = 1'b0;
        case (state_r)
            ST_COLLECT: begin
                if (accept_s) begin
                    store_s = 1'b1;
                    if (idx_r == LAST_IDX) begin
                        if (s_axis_last) begin
                            state_nxt_s = ST_HOLD;
                        end else begin
                            frame_err_s = 1'b1;
                            state_nxt_s = ST_DRAIN;
                        end
                    end else if (s_axis_last) begin
                        frame_err_s = 1'b1;
                        idx_clr_s   = 1'b1;
                    end else begin
                        idx_clr_s   = 1'b0;
                    end
                end else begin
                    store_s = 1'b0;
                end
            end
            ST_DRAIN: begin
                if (accept_s && s_axis_last) begin
                    idx_clr_s   = 1'b1;
                    state_nxt_s = ST_COLLECT;
                end else begin
                    state_nxt_s = ST_DRAIN;
                end
            end
            ST_HOLD: begin
                if (valid_r && frm_ready) begin
                    deliver_s   = 1'b1;
                    idx_clr_s   = 1'b1;
                    state_nxt_s = ST_COLLECT;
                end else begin
                    state_nxt_s = ST_HOLD;
                end
            end
            default: begin
                state_nxt_s = ST_COLLECT;
                idx_clr_s   = 1'b1;
            end
        endcase
    end

    // Handshake flags, word index and statistics
    always_ff @(posedge axis_clk or negedge axis_reset_n) begin
        if (!axis_reset_n) begin
            ready_r   <= 1'b0;
            valid_r   <= 1'b0;
            err_r     <= 1'b0;
            idx_r     <= {IDX_W{1'b0}};
            frm_cnt_r <= {CNT_W{1'b0}};
            err_cnt_r <= {CNT_W{1'b0}};
        end else begin
            // Both flags are decoded from the next state so they stay pure registers
            ready_r <= (state_nxt_s != ST_HOLD);
            valid_r <= (state_nxt_s == ST_HOLD);
            err_r   <= frame_err_s;
            if (idx_clr_s) begin
                idx_r <= {IDX_W{1'b0}};
            end else if (store_s && (idx_r != LAST_IDX)) begin
                idx_r <= idx_r + {{(IDX_W-1){1'b0}}, 1'b1};
            end
            if (deliver_s) begin
                frm_cnt_r <= frm_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            if (frame_err_s) begin
                err_cnt_r <= err_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    // Field shift registers: each word enters at the LSB so the first word ends up on top
    always_ff @(posedge axis_clk or negedge axis_reset_n) begin
        if (!axis_reset_n) begin
            key_r   <= {(KEY_WORDS*32){1'b0}};
            nonce_r <= {(NONCE_WORDS*32){1'b0}};
            ctr_r   <= {(CTR_WORDS*32){1'b0}};
            data_r  <= {(DATA_WORDS*32){1'b0}};
        end else if (store_s) begin
            if (idx_r < NONCE_BASE) begin
                key_r <= {key_r[KEY_WORDS*32-33:0], s_axis_data};
            end else if (idx_r < CTR_BASE) begin
                nonce_r <= {nonce_r[NONCE_WORDS*32-33:0], s_axis_data};
            end else if (idx_r < DATA_BASE) begin
                ctr_r <= {ctr_r[CTR_WORDS*32-33:0], s_axis_data};
            end else begin
                data_r <= {data_r[DATA_WORDS*32-33:0], s_axis_data};
            end
        end
    end

endmodule

// File: tb/tb_axis_frame_receiver.sv
// Directed self-checking bench for axis_frame_receiver.
module tb_axis_frame_receiver;

    logic          axis_clk;
    logic          axis_reset_n;
    logic          s_axis_valid;
    logic [31:0]   s_axis_data;
    logic          s_axis_last;
    logic          s_axis_ready;
    logic          frm_valid;
    logic          frm_ready;
    logic [255:0]  frm_key;
    logic [63:0]   frm_nonce;
    logic [63:0]   frm_counter;
    logic [511:0]  frm_data;
    logic          frm_err;
    logic [15:0]   frm_count;
    logic [15:0]   err_count;

    int n_checks = 0;
    int n_errors = 0;
    int err_pulses = 0;
    int valid_rises = 0;
    logic valid_q = 1'b0;
    int err_at;
    int snap_err;
    int snap_rise;
    logic [255:0] ek;
    logic [63:0]  en;
    logic [63:0]  ec;
    logic [511:0] ed;

    axis_frame_receiver dut (
        .axis_clk     (axis_clk),
        .axis_reset_n (axis_reset_n),
        .s_axis_valid (s_axis_valid),
        .s_axis_data  (s_axis_data),
        .s_axis_last  (s_axis_last),
        .s_axis_ready (s_axis_ready),
        .frm_valid    (frm_valid),
        .frm_ready    (frm_ready),
        .frm_key      (frm_key),
        .frm_nonce    (frm_nonce),
        .frm_counter  (frm_counter),
        .frm_data     (frm_data),
        .frm_err      (frm_err),
        .frm_count    (frm_count),
        .err_count    (err_count)
    );

    initial axis_clk = 1'b0;
    always #5 axis_clk = ~axis_clk;

    always @(negedge axis_clk) begin
        if (frm_err) err_pulses++;
        if (frm_valid && !valid_q) valid_rises++;
        valid_q = frm_valid;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] word_of(input int i, input int s);
        logic [31:0] b;
        if (i < 8)        b = 32'h1000_0000 + 32'(i);
        else if (i == 8)  b = 32'hAAAA_0001;
        else if (i == 9)  b = 32'h0000_0002;
        else if (i == 10) b = 32'h0000_0000;
        else if (i == 11) b = 32'h0000_0005;
        else              b = 32'hD000_0000 + 32'(i - 12);
        return b ^ (32'(s) << 16);
    endfunction

    task automatic build_exp(input int s);
        ek = '0; en = '0; ec = '0; ed = '0;
        for (int i = 0; i < 8; i++)   ek = {ek[223:0], word_of(i, s)};
        for (int i = 8; i < 10; i++)  en = {en[31:0], word_of(i, s)};
        for (int i = 10; i < 12; i++) ec = {ec[31:0], word_of(i, s)};
        for (int i = 12; i < 28; i++) ed = {ed[479:0], word_of(i, s)};
    endtask

    // Drives n words (last flagged on index last_at); ends on the negedge after the final accept
    task automatic send_frame(input int n, input int last_at, input int s, input bit gapped);
        bit all_got = 1'b1;
        err_at = -1;
        for (int i = 0; i < n; i++) begin
            bit got = 1'b0;
            if (gapped) begin
                int gap = $urandom_range(0, 2);
                s_axis_valid = 1'b0;
                for (int g = 0; g < gap; g++) @(negedge axis_clk);
            end
            s_axis_valid = 1'b1;
            s_axis_data  = word_of(i, s);
            s_axis_last  = (i == last_at);
            for (int t = 0; t < 64 && !got; t++) begin
                if (s_axis_ready) got = 1'b1;
                @(negedge axis_clk);
            end
            if (!got) all_got = 1'b0;
            if (frm_err) err_at = i;
        end
        s_axis_valid = 1'b0;
        s_axis_last  = 1'b0;
        check("frame_accept", 512'(all_got), 512'd1);
    endtask

    task automatic check_frame(input string tag);
        check({tag, "_valid"}, 512'(frm_valid), 512'd1);
        check({tag, "_key"},   512'(frm_key), 512'(ek));
        check({tag, "_nonce"}, 512'(frm_nonce), 512'(en));
        check({tag, "_ctr"},   512'(frm_counter), 512'(ec));
        check({tag, "_data"},  frm_data, ed);
    endtask

    initial begin
        axis_reset_n = 1'b0;
        s_axis_valid = 1'b0;
        s_axis_data  = 32'h0;
        s_axis_last  = 1'b0;
        frm_ready    = 1'b1;
        repeat (3) @(negedge axis_clk);
        check("rst_ready", 512'(s_axis_ready), 512'd0);
        check("rst_valid", 512'(frm_valid), 512'd0);
        check("rst_err",   512'(frm_err), 512'd0);
        check("rst_bus",   512'({frm_key, frm_nonce, frm_counter} | 384'(frm_data)), 512'd0);
        check("rst_cnt",   512'({frm_count, err_count}), 512'd0);
        axis_reset_n = 1'b1;
        @(negedge axis_clk);
        check("rel_ready", 512'(s_axis_ready), 512'd1);

        // Single frame with hand-computed field values
        send_frame(28, 27, 0, 1'b0);
        check("f0_key_w0", 512'(frm_key[255:224]), 512'(32'h1000_0000));
        check("f0_nonce",  512'(frm_nonce), 512'(64'hAAAA_0001_0000_0002));
        check("f0_ctr",    512'(frm_counter), 512'd5);
        check("f0_data_lo", 512'(frm_data[31:0]), 512'(32'hD000_000F));
        check("f0_data_hi", 512'(frm_data[511:480]), 512'(32'hD000_0000));
        check("f0_ready_hold", 512'(s_axis_ready), 512'd0);
        build_exp(0);
        check_frame("f0");
        @(negedge axis_clk);
        check("f0_done", 512'({frm_valid, s_axis_ready, frm_count}), 512'({1'b0, 1'b1, 16'd1}));

        // Backpressure: hold 10 cycles with frm_ready low
        frm_ready = 1'b0;
        build_exp(1);
        send_frame(28, 27, 1, 1'b0);
        for (int c = 0; c < 10; c++) begin
            check("bp_hold", 512'({s_axis_ready, frm_valid, frm_key == ek, frm_data == ed,
                                    frm_nonce == en, frm_counter == ec}), 512'(6'b011111));
            @(negedge axis_clk);
        end
        frm_ready = 1'b1;
        @(negedge axis_clk);
        check("bp_release", 512'({frm_valid, s_axis_ready, frm_count}), 512'({1'b0, 1'b1, 16'd2}));

        // Short frame then a good frame
        snap_err = err_pulses; snap_rise = valid_rises;
        send_frame(12, 11, 2, 1'b0);
        repeat (3) @(negedge axis_clk);
        check("short_err_at", 512'(err_at), 512'd11);
        check("short_pulses", 512'(err_pulses - snap_err), 512'd1);
        check("short_err_cnt", 512'(err_count), 512'd1);
        check("short_no_valid", 512'(valid_rises - snap_rise), 512'd0);
        build_exp(3);
        send_frame(28, 27, 3, 1'b0);
        check_frame("after_short");
        @(negedge axis_clk);
        check("after_short_cnt", 512'(frm_count), 512'd3);

        // Long frame: error on word 27, drain through word 30
        snap_err = err_pulses; snap_rise = valid_rises;
        send_frame(31, 30, 4, 1'b0);
        repeat (3) @(negedge axis_clk);
        check("long_err_at", 512'(err_at), 512'd27);
        check("long_pulses", 512'(err_pulses - snap_err), 512'd1);
        check("long_err_cnt", 512'(err_count), 512'd2);
        check("long_no_valid", 512'(valid_rises - snap_rise), 512'd0);
        build_exp(5);
        send_frame(28, 27, 5, 1'b0);
        check_frame("after_long");
        @(negedge axis_clk);
        check("after_long_cnt", 512'(frm_count), 512'd4);

        // Gapped input must yield the same frame as gapless
        build_exp(0);
        send_frame(28, 27, 0, 1'b1);
        check_frame("gapped");
        @(negedge axis_clk);
        check("gapped_cnt", 512'(frm_count), 512'd5);

        // Reset while in HOLD
        frm_ready = 1'b0;
        send_frame(28, 27, 7, 1'b0);
        check("hold_pre", 512'(frm_valid), 512'd1);
        #2 axis_reset_n = 1'b0;
        #1;
        check("hold_rst", 512'({frm_valid, s_axis_ready, frm_err, frm_count, err_count}), 512'd0);
        check("hold_rst_bus", 512'(frm_key) | frm_data, 512'd0);
        @(negedge axis_clk);
        axis_reset_n = 1'b1;
        frm_ready = 1'b1;

        // Reset mid-frame after the key has been shifted in
        for (int i = 0; i < 10; i++) begin
            s_axis_valid = 1'b1;
            s_axis_data  = word_of(i, 9);
            s_axis_last  = 1'b0;
            @(negedge axis_clk);
        end
        s_axis_valid = 1'b0;
        #2 axis_reset_n = 1'b0;
        #1;
        check("mid_rst_key", 512'(frm_key), 512'd0);
        check("mid_rst_ready", 512'(s_axis_ready), 512'd0);
        @(negedge axis_clk);
        axis_reset_n = 1'b1;
        build_exp(8);
        send_frame(28, 27, 8, 1'b0);
        check_frame("post_rst");
        @(negedge axis_clk);
        check("post_rst_cnt", 512'({frm_count, err_count}), 512'({16'd1, 16'd0}));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
